// File: rtl/cnt_cmd_sequencer.sv
// rtl/cnt_cmd_sequencer.sv - command sequencer driving a 16-bit up/down counter; optional shadow checker under CNT_SEQ_CHECK_EN
module cnt_cmd_sequencer #(
    parameter int WIDTH  = 16,
    parameter int STEP_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    output logic             ld_cnt,
    output logic             updn_cnt,
    output logic             count_enb,
    output logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_HOLD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_HOLD
    } state_e;

    state_e            state_q;
    logic [STEP_W-1:0] remaining_q;
    logic              cmd_ready_q;
    logic              ld_cnt_q;
    logic              updn_cnt_q;
    logic              count_enb_q;
    logic [WIDTH-1:0]  data_in_q;
    logic              busy_q;
    logic              done_q;

    logic [STEP_W-1:0] step_d;
    logic              last_d;

    assign step_d = cmd_arg[STEP_W-1:0];
    // LOAD is always a single cycle; RUN/HOLD end when the count reaches 1.
    assign last_d = (state_q == S_LOAD) || (remaining_q == STEP_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            cmd_ready_q <= 1'b1;
            ld_cnt_q    <= 1'b1;
            updn_cnt_q  <= 1'b1;
            count_enb_q <= 1'b0;
            data_in_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == S_IDLE) begin
                if (cmd_valid && cmd_ready_q) begin
                    if (cmd_op == OP_LOAD) begin
                        state_q     <= S_LOAD;
                        ld_cnt_q    <= 1'b0;
                        data_in_q   <= cmd_arg;
                        busy_q      <= 1'b1;
                        cmd_ready_q <= 1'b0;
                    end else if (step_d == '0) begin
                        done_q <= 1'b1;
                    end else begin
                        remaining_q <= step_d;
                        busy_q      <= 1'b1;
                        cmd_ready_q <= 1'b0;
                        if (cmd_op == OP_HOLD) begin
                            state_q <= S_HOLD;
                        end else begin
                            state_q     <= S_RUN;
                            count_enb_q <= 1'b1;
                            updn_cnt_q  <= (cmd_op == OP_UP);
                        end
                    end
                end
            end else if (last_d) begin
                state_q     <= S_IDLE;
                remaining_q <= '0;
                ld_cnt_q    <= 1'b1;
                count_enb_q <= 1'b0;
                data_in_q   <= '0;
                busy_q      <= 1'b0;
                cmd_ready_q <= 1'b1;
                done_q      <= 1'b1;
            end else begin
                remaining_q <= remaining_q - STEP_W'(1);
            end
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign ld_cnt    = ld_cnt_q;
    assign updn_cnt  = updn_cnt_q;
    assign count_enb = count_enb_q;
    assign data_in   = data_in_q;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef CNT_SEQ_CHECK_EN
    logic [WIDTH-1:0] exp_q;
    logic             exp_vld_q;
    logic             chk_q;
    logic             err_q;

    // The counter reflects a LOAD/RUN cycle one edge later, so compare in the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q     <= '0;
            exp_vld_q <= 1'b0;
            chk_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            chk_q <= (state_q == S_LOAD) || (state_q == S_RUN);
            if (state_q == S_LOAD) begin
                exp_q     <= data_in_q;
                exp_vld_q <= 1'b1;
            end else if (state_q == S_RUN) begin
                exp_q <= updn_cnt_q ? exp_q + WIDTH'(1) : exp_q - WIDTH'(1);
            end
            if (chk_q && exp_vld_q && (data_out != exp_q)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    logic unused_data_out;
    assign unused_data_out = ^data_out;
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cnt_cmd_sequencer.sv
// tb/tb_cnt_cmd_sequencer.sv - self-checking bench for cnt_cmd_sequencer with a counter model and trace scoreboard
module tb_cnt_cmd_sequencer;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic [1:0]   cmd_op = 2'b00;
    logic [W-1:0] cmd_arg = '0;
    logic         cmd_ready, ld_cnt, updn_cnt, count_enb, busy, done, err;
    logic [W-1:0] data_in, data_out;

    logic [W-1:0] cnt = '0;
    logic         frc_en = 1'b0;
    logic [W-1:0] frc_val = '0;

    always #5 clk = ~clk;

    assign data_out = frc_en ? frc_val : cnt;

    cnt_cmd_sequencer #(.WIDTH(W), .STEP_W(16)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .ld_cnt(ld_cnt), .updn_cnt(updn_cnt),
        .count_enb(count_enb), .data_in(data_in), .data_out(data_out),
        .busy(busy), .done(done), .err(err)
    );

    typedef struct packed {
        logic         ready;
        logic         ld;
        logic         updn;
        logic         enb;
        logic [W-1:0] din;
        logic         busy;
        logic         done;
    } exp_t;

    exp_t         sched[$];
    exp_t         cur;
    exp_t         act;
    logic         m_live = 1'b0;
    logic         m_acc = 1'b0;
    logic [W-1:0] mexp = '0;
    logic         mvld = 1'b0;
    logic         mchk = 1'b0;
    logic         merr = 1'b0;
    logic         err_exp;
    int           n_pass = 0;
    int           n_total = 0;

    function automatic exp_t idle_rec(input logic u, input logic d);
        return '{ready: 1'b1, ld: 1'b1, updn: u, enb: 1'b0, din: '0, busy: 1'b0, done: d};
    endfunction

    function automatic exp_t act_rec(input logic l, input logic u, input logic e, input logic [W-1:0] v);
        return '{ready: 1'b0, ld: l, updn: u, enb: e, din: v, busy: 1'b1, done: 1'b0};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, want);
    endtask

    // Model: each accepted command expands into its full per-cycle output trace.
    initial begin
        forever begin
            @(posedge clk);
            m_acc = 1'b0;
            if (rst) begin
                sched.delete();
                cur  = idle_rec(1'b1, 1'b0);
                mexp = '0;
                mvld = 1'b0;
                mchk = 1'b0;
                merr = 1'b0;
            end else begin
`ifdef CNT_SEQ_CHECK_EN
                if (mchk && mvld && data_out != mexp) merr = 1'b1;
                mchk = 1'b0;
                if (!cur.ld) begin
                    mexp = cur.din; mvld = 1'b1; mchk = 1'b1;
                end else if (cur.enb) begin
                    mexp = cur.updn ? mexp + 16'd1 : mexp - 16'd1; mchk = 1'b1;
                end
`endif
                if (cur.ready && cmd_valid) begin
                    int n;
                    logic u;
                    m_acc = 1'b1;
                    n = int'(cmd_arg);
                    case (cmd_op)
                        2'd0: begin
                            sched.push_back(act_rec(1'b0, cur.updn, 1'b0, cmd_arg));
                            sched.push_back(idle_rec(cur.updn, 1'b1));
                        end
                        2'd3: begin
                            for (int i = 0; i < n; i++) sched.push_back(act_rec(1'b1, cur.updn, 1'b0, '0));
                            sched.push_back(idle_rec(cur.updn, 1'b1));
                        end
                        default: begin
                            u = (n == 0) ? cur.updn : (cmd_op == 2'd1);
                            for (int i = 0; i < n; i++) sched.push_back(act_rec(1'b1, u, 1'b1, '0));
                            sched.push_back(idle_rec(u, 1'b1));
                        end
                    endcase
                end
                cur = (sched.size() > 0) ? sched.pop_front() : idle_rec(cur.updn, 1'b0);
            end
            if (!ld_cnt) cnt <= data_in;
            else if (count_enb) cnt <= updn_cnt ? cnt + 16'd1 : cnt - 16'd1;
            m_live = 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_live) begin
                act = '{ready: cmd_ready, ld: ld_cnt, updn: updn_cnt, enb: count_enb,
                        din: data_in, busy: busy, done: done};
                chk("cycle", {8'h0, act, err}, {8'h0, cur, merr});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [W-1:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (m_acc) break;
        end
        chk("accept", {31'h0, m_acc}, 32'h1);
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_arg   = W'($urandom);
    endtask

    initial begin
`ifdef CNT_SEQ_CHECK_EN
        err_exp = 1'b1;
`else
        err_exp = 1'b0;
`endif
        rst = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd0; cmd_arg = 16'h5555;
        tick(3);
        chk("rst_out", {27'h0, cmd_ready, ld_cnt, count_enb, busy, done}, 32'b11000);
        chk("rst_noload", {16'h0, data_out}, 32'h0);
        rst = 1'b0; cmd_valid = 1'b0;
        tick(1);

        send(2'd0, 16'h1234);
        chk("load_drive", {15'h0, ld_cnt, data_in, busy}, {15'h0, 1'b0, 16'h1234, 1'b1});
        tick(1);
        chk("load_done", {14'h0, done, busy, data_out}, {14'h0, 1'b1, 1'b0, 16'h1234});

        send(2'd0, 16'hFFFE);
        send(2'd1, 16'd3);
        chk("up_drive", {30'h0, count_enb, updn_cnt}, 32'h3);
        tick(1); chk("up_1", {16'h0, data_out}, 32'hFFFF);
        tick(1); chk("up_2", {16'h0, data_out}, 32'h0000);
        tick(1); chk("up_3", {15'h0, done, data_out}, {15'h0, 1'b1, 16'h0001});
        chk("up_err", {31'h0, err}, 32'h0);
        tick(1); chk("up_single_done", {31'h0, done}, 32'h0);

        send(2'd0, 16'h0001);
        send(2'd2, 16'd2);
        chk("dn_drive", {30'h0, count_enb, updn_cnt}, 32'h2);
        tick(1); chk("dn_1", {16'h0, data_out}, 32'h0000);
        tick(1); chk("dn_2", {15'h0, done, data_out}, {15'h0, 1'b1, 16'hFFFF});
        send(2'd3, 16'd4);
        for (int i = 0; i < 4; i++) begin
            chk("hold_stable", {15'h0, count_enb, data_out}, {15'h0, 1'b0, 16'hFFFF});
            if (i < 3) tick(1);
        end
        tick(1); chk("hold_done", {14'h0, done, busy, data_out}, {14'h0, 1'b1, 1'b0, 16'hFFFF});

        send(2'd1, 16'd0);
        chk("up0_done", {14'h0, done, busy, data_out}, {14'h0, 1'b1, 1'b0, 16'hFFFF});
        send(2'd1, 16'd10);
        tick(3);
        rst = 1'b1;
        tick(1);
        chk("rst_mid", {27'h0, busy, count_enb, ld_cnt, done, cmd_ready}, 32'b00101);
        chk("rst_mid_cnt", {16'h0, data_out}, 32'h0003);
        rst = 1'b0;
        tick(1);
        chk("rst_no_done", {15'h0, done, data_out}, {15'h0, 1'b0, 16'h0003});

        send(2'd0, 16'h0010);
        send(2'd1, 16'd2);
        tick(1); chk("chk_run1", {16'h0, data_out}, 32'h0011);
        tick(1); chk("chk_run2", {15'h0, done, data_out}, {15'h0, 1'b1, 16'h0012});
        frc_val = 16'h0013;
        frc_en  = 1'b1;
        tick(1); chk("err_set", {31'h0, err}, {31'h0, err_exp});
        tick(3); chk("err_sticky", {31'h0, err}, {31'h0, err_exp});
        frc_en = 1'b0;
        rst    = 1'b1;
        tick(1); chk("err_clr", {31'h0, err}, 32'h0);
        rst = 1'b0;
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
